// File: rtl/hdmi_island_scheduler_if.sv
// Bundle between the video timing sequencer, the island scheduler and the aux packer.
//   blank           : 1 = blanking interval
//   blank_remaining : blanking cycles left, including the current one (valid when blank=1)
//   ready           : per-source packet available, [0] = audio sample
//   grant           : one-hot source grant, held for the 32 data cycles of a packet
//   phase           : 000 control, 101 aux preamble, 100 aux guard, 001 aux data
//   slot            : packet slot 0..31 in data phase, 0 otherwise
//   packet_end      : pulse on slot 31 of each packet
//   island_end      : pulse on the last trailing-guard cycle
//   overrun         : sticky, blank fell while an island was active
// master = timing/source side, slave = scheduler.
interface hdmi_island_scheduler_if;
    logic        blank;
    logic [11:0] blank_remaining;
    logic [3:0]  ready;
    logic [3:0]  grant;
    logic [2:0]  phase;
    logic [4:0]  slot;
    logic        packet_end;
    logic        island_end;
    logic        overrun;

    modport master (
        output blank, blank_remaining, ready,
        input  grant, phase, slot, packet_end, island_end, overrun
    );

    modport slave (
        input  blank, blank_remaining, ready,
        output grant, phase, slot, packet_end, island_end, overrun
    );
endinterface

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler. Places islands (preamble, leading guard, 1..MAX_PACKETS packets
// of 32 data cycles, trailing guard) inside blanking and arbitrates four aux packet sources:
// audio sample (strict priority) and a round-robin over the other three.
//   clk    : pixel clock
//   rst    : asynchronous reset, active-high
//   bus_io : scheduler side of hdmi_island_scheduler_if (see the interface for signal meaning)
// All outputs are registered and reflect the current state.
module hdmi_island_scheduler #(
    parameter int unsigned MAX_PACKETS = 2,
    parameter int unsigned MIN_CTRL    = 12,
    parameter int unsigned TAIL_MARGIN = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    hdmi_island_scheduler_if.slave     bus_io
);

    localparam logic [2:0] StCtrl   = 3'd0;
    localparam logic [2:0] StPre    = 3'd1;
    localparam logic [2:0] StLguard = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StTguard = 3'd4;

    localparam int unsigned CtrlW = (MIN_CTRL > 0) ? $clog2(MIN_CTRL + 1) : 1;

    logic [2:0]       state_q, state_d;
    logic [4:0]       cyc_q, cyc_d;
    logic [CtrlW-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [4:0]       pkt_cnt_q, pkt_cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [2:0]       phase_q, phase_d;
    logic [4:0]       slot_q, slot_d;
    logic             packet_end_q, packet_end_d;
    logic             island_end_q, island_end_d;
    logic             overrun_q, overrun_d;

    logic [3:0] arb_req, arb_grant;
    logic [1:0] arb_rr;
    logic [2:0] cand;
    logic       start, cont;

    // Arbiter. During data the just-served source is masked for the continue decision.
    always_comb begin
        arb_req   = (state_q == StData) ? (bus_io.ready & ~grant_q) : bus_io.ready;
        arb_grant = 4'b0000;
        arb_rr    = rr_ptr_q;
        cand      = 3'd0;
        if (arb_req[0]) begin
            arb_grant = 4'b0001;
        end else begin
            // Scan furthest-from-pointer first so the nearest ready source is written last.
            for (int k = 2; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + 3'(k);
                if (cand > 3'd3) cand = cand - 3'd3;
                if (arb_req[cand[1:0]]) begin
                    arb_grant = 4'b0001 << cand;
                    arb_rr    = (cand == 3'd3) ? 2'd1 : cand[1:0] + 2'd1;
                end
            end
        end
    end

    assign start = bus_io.blank && (|bus_io.ready) && (ctrl_cnt_q >= CtrlW'(MIN_CTRL)) &&
                   (bus_io.blank_remaining >= 12'(44 + TAIL_MARGIN));
    assign cont  = (|arb_req) && (pkt_cnt_q < 5'(MAX_PACKETS)) &&
                   (bus_io.blank_remaining >= 12'(35 + TAIL_MARGIN));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + 5'd1;
        ctrl_cnt_d = ctrl_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        grant_d    = grant_q;
        overrun_d  = overrun_q;

        case (state_q)
            StCtrl: begin
                cyc_d = 5'd0;
                if (!bus_io.blank) begin
                    ctrl_cnt_d = '0;
                end else if (ctrl_cnt_q < CtrlW'(MIN_CTRL)) begin
                    ctrl_cnt_d = ctrl_cnt_q + 1'b1;
                end
                if (start) begin
                    state_d    = StPre;
                    ctrl_cnt_d = '0;
                    pkt_cnt_d  = 5'd0;
                end
            end
            StPre: begin
                if (cyc_q == 5'd7) begin
                    state_d = StLguard;
                    cyc_d   = 5'd0;
                end
            end
            StLguard: begin
                if (cyc_q == 5'd1) begin
                    // A source that withdrew since the start yields a null packet (grant=0);
                    // the island still runs to completion.
                    state_d   = StData;
                    cyc_d     = 5'd0;
                    grant_d   = arb_grant;
                    rr_ptr_d  = arb_rr;
                    pkt_cnt_d = pkt_cnt_q + 5'd1;
                end
            end
            StData: begin
                if (cyc_q == 5'd31) begin
                    if (cont) begin
                        grant_d   = arb_grant;  // cyc wraps 31->0 with no gap
                        rr_ptr_d  = arb_rr;
                        pkt_cnt_d = pkt_cnt_q + 5'd1;
                    end else begin
                        state_d = StTguard;
                        cyc_d   = 5'd0;
                        grant_d = 4'b0000;
                    end
                end
            end
            StTguard: begin
                if (cyc_q == 5'd1) begin
                    state_d = StCtrl;
                    cyc_d   = 5'd0;
                end
            end
            default: begin
                state_d = StCtrl;
                cyc_d   = 5'd0;
            end
        endcase

        // Blanking ended under an active island: drop straight back to control.
        if ((state_q != StCtrl) && !bus_io.blank) begin
            state_d    = StCtrl;
            cyc_d      = 5'd0;
            grant_d    = 4'b0000;
            ctrl_cnt_d = '0;
            overrun_d  = 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registers track the state they describe.
    always_comb begin
        case (state_d)
            StPre:             phase_d = 3'b101;
            StLguard, StTguard: phase_d = 3'b100;
            StData:            phase_d = 3'b001;
            default:           phase_d = 3'b000;
        endcase
        slot_d       = (state_d == StData) ? cyc_d : 5'd0;
        packet_end_d = (state_d == StData) && (cyc_d == 5'd31);
        island_end_d = (state_d == StTguard) && (cyc_d == 5'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StCtrl;
            cyc_q        <= 5'd0;
            ctrl_cnt_q   <= '0;
            rr_ptr_q     <= 2'd1;
            pkt_cnt_q    <= 5'd0;
            grant_q      <= 4'b0000;
            phase_q      <= 3'b000;
            slot_q       <= 5'd0;
            packet_end_q <= 1'b0;
            island_end_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            grant_q      <= grant_d;
            phase_q      <= phase_d;
            slot_q       <= slot_d;
            packet_end_q <= packet_end_d;
            island_end_q <= island_end_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus_io.grant      = grant_q;
    assign bus_io.phase      = phase_q;
    assign bus_io.slot       = slot_q;
    assign bus_io.packet_end = packet_end_q;
    assign bus_io.island_end = island_end_q;
    assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Scoreboard bench for hdmi_island_scheduler. A driver issues per-cycle blanking/ready stimulus
// and pushes the reference model's expected outputs into a queue; a monitor on the falling
// edge pops and compares. The model tracks each island as an offset from its start.
module tb_hdmi_island_scheduler;

    localparam int MAX_PACKETS = 2;
    localparam int MIN_CTRL    = 12;
    localparam int TAIL_MARGIN = 12;

    typedef struct packed {
        logic [3:0] grant;
        logic [2:0] phase;
        logic [4:0] slot;
        logic       pe;
        logic       ie;
        logic       ov;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hdmi_island_scheduler_if bus();

    hdmi_island_scheduler #(
        .MAX_PACKETS (MAX_PACKETS),
        .MIN_CTRL    (MIN_CTRL),
        .TAIL_MARGIN (TAIL_MARGIN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    // Reference model state: island offset o counts cycles since the island's first preamble
    // cycle; data occupies offsets 10 .. 10+32*npk-1, trailing guard the next two.
    bit         m_active;
    int         m_o, m_npk, m_ctrl, m_rr;
    bit         m_ov;
    logic [3:0] m_grant;

    task automatic model_reset();
        m_active = 0; m_o = 0; m_npk = 0; m_ctrl = 0; m_rr = 1; m_ov = 0; m_grant = 4'b0;
    endtask

    function automatic logic [3:0] pick(input logic [3:0] req);
        int s;
        if (req[0]) return 4'b0001;
        for (int k = 0; k < 3; k++) begin
            s = (m_rr - 1 + k) % 3 + 1;
            if (req[s]) begin
                m_rr = s % 3 + 1;
                return 4'(1 << s);
            end
        end
        return 4'b0000;
    endfunction

    task automatic model_step(input bit b, input logic [11:0] rem, input logic [3:0] rdy);
        bit st;
        if (!m_active) begin
            st = b && (rdy != 0) && (m_ctrl >= MIN_CTRL) && (int'(rem) >= 44 + TAIL_MARGIN);
            m_ctrl = b ? ((m_ctrl < MIN_CTRL) ? m_ctrl + 1 : m_ctrl) : 0;
            if (st) begin
                m_active = 1; m_o = 0; m_npk = 0; m_ctrl = 0; m_grant = 4'b0;
            end
        end else if (!b) begin
            m_active = 0; m_ov = 1; m_ctrl = 0; m_grant = 4'b0;
        end else begin
            if (m_o == 9) begin
                m_grant = pick(rdy);
                m_npk = 1;
            end else if (m_o >= 10 && m_o < 10 + 32 * m_npk && (m_o - 10) % 32 == 31) begin
                if ((rdy & ~m_grant) != 0 && m_npk < MAX_PACKETS &&
                    int'(rem) >= 35 + TAIL_MARGIN) begin
                    m_grant = pick(rdy & ~m_grant);
                    m_npk++;
                end else begin
                    m_grant = 4'b0;
                end
            end
            if (m_npk > 0 && m_o == 10 + 32 * m_npk + 1) m_active = 0;
            else m_o++;
        end
    endtask

    function automatic out_t model_out();
        out_t r;
        r = '0;
        r.ov = m_ov;
        if (m_active) begin
            r.grant = m_grant;
            if (m_o < 8) r.phase = 3'b101;
            else if (m_o < 10) r.phase = 3'b100;
            else if (m_o < 10 + 32 * m_npk) begin
                r.phase = 3'b001;
                r.slot  = 5'((m_o - 10) % 32);
                r.pe    = (r.slot == 5'd31);
            end else begin
                r.phase = 3'b100;
                r.ie    = (m_o == 10 + 32 * m_npk + 1);
            end
        end
        return r;
    endfunction

    task automatic drive(input bit b, input logic [11:0] rem, input logic [3:0] rdy, input bit r);
        bit rst_prev;
        @(posedge clk);
        #1;
        rst_prev = rst;
        rst = r;
        bus.blank = b;
        bus.blank_remaining = rem;
        bus.ready = rdy;
        cyc_no++;
        if (r) begin
            model_reset();
            if (!rst_prev) begin
                // Reset is asynchronous: the pending expectation for this cycle is void.
                exp_q.delete();
                exp_q.push_back('0);
            end
            exp_q.push_back('0);
        end else begin
            model_step(b, rem, rdy);
            exp_q.push_back(model_out());
        end
    endtask

    function automatic logic [3:0] gen_ready(input int mode, input logic [3:0] fixed);
        case (mode)
            1: return fixed;
            2: return 4'b1111;
            3: return ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic blank_seg(input int len, input int drop_at, input int rst_at, input int mode,
                             input logic [3:0] fixed);
        bit b, r;
        for (int i = 0; i < len; i++) begin
            b = (drop_at < 0) || (i < drop_at);
            r = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 3);
            drive(b, 12'(len - i), gen_ready(mode, fixed), r);
        end
    endtask

    task automatic active_seg(input int len);
        for (int i = 0; i < len; i++) drive(1'b0, 12'($urandom), 4'($urandom), 1'b0);
    endtask

    // Monitor: compare current DUT outputs against the oldest expectation.
    initial begin
        out_t e, a;
        forever begin
            @(negedge clk);
            a = {bus.grant, bus.phase, bus.slot, bus.packet_end, bus.island_end, bus.overrun};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cyc_no);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got grant=%b phase=%b slot=%0d pe=%b ie=%b ov=%b, expected grant=%b phase=%b slot=%0d pe=%b ie=%b ov=%b",
                             cyc_no, a.grant, a.phase, a.slot, a.pe, a.ie, a.ov,
                             e.grant, e.phase, e.slot, e.pe, e.ie, e.ov);
                end
            end
        end
    end

    initial begin
        int len;
        bus.blank = 1'b0;
        bus.blank_remaining = 12'd0;
        bus.ready = 4'b0;
        model_reset();
        exp_q.push_back('0);

        for (int i = 0; i < 4; i++) drive(1'b0, 12'd0, 4'b0, 1'b1);

        // Single audio packet island.
        blank_seg(300, -1, -1, 1, 4'b0001);
        active_seg(20);
        // All sources ready: rotation across several islands.
        for (int i = 0; i < 3; i++) begin
            blank_seg(300, -1, -1, 2, 4'b0);
            active_seg(10);
        end
        // Start threshold: 55 remaining at the decision point refuses, 56 accepts.
        blank_seg(67, -1, -1, 1, 4'b0010);
        active_seg(10);
        blank_seg(68, -1, -1, 1, 4'b0010);
        active_seg(10);
        // Continue threshold: 46 remaining at the first slot 31 refuses, 47 accepts.
        blank_seg(100, -1, -1, 1, 4'b0110);
        active_seg(10);
        blank_seg(101, -1, -1, 1, 4'b0110);
        active_seg(10);
        // Blank drops at data slot 10; overrun must stay set through later islands.
        blank_seg(300, 33, -1, 1, 4'b0001);
        active_seg(10);
        blank_seg(120, -1, -1, 1, 4'b1000);
        active_seg(10);
        // Reset pulse in the middle of a preamble.
        blank_seg(200, -1, 14, 1, 4'b0100);
        active_seg(10);

        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(40, 400);
            blank_seg(len,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(13, len - 1) : -1,
                      ($urandom_range(0, 14) == 0) ? $urandom_range(0, len - 4) : -1,
                      $urandom_range(0, 3), 4'($urandom));
            active_seg($urandom_range(1, 50));
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
